// File: rtl/fastio_bank_ctrl_if.sv
// Wishbone slave bus bundle for the fastio bank controller.
// Signal names follow the Caravel wbs_* port naming.
interface fastio_bank_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fastio_bank_ctrl.sv
// Register-mapped bank of fast GPIO pads behind a Wishbone slave: output, enable,
// drive strength, atomic set/clear/toggle, synchronised inputs and edge interrupts.
module fastio_bank_ctrl #(
  parameter int unsigned CHANNELS    = 28,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  fastio_bank_ctrl_if.slave   wbs,
  input  logic [CHANNELS-1:0] fastio_in,
  output logic [CHANNELS-1:0] fastio_out_l,
  output logic [CHANNELS-1:0] fastio_oe_l,
  output logic [CHANNELS-1:0] fastio_med_enable,
  output logic [CHANNELS-1:0] fastio_strong_enable,
  output logic                irq
);

  localparam logic [5:0] OffOut    = 6'h00;
  localparam logic [5:0] OffOe     = 6'h01;
  localparam logic [5:0] OffMed    = 6'h02;
  localparam logic [5:0] OffStrong = 6'h03;
  localparam logic [5:0] OffIn     = 6'h04;
  localparam logic [5:0] OffSet    = 6'h05;
  localparam logic [5:0] OffClr    = 6'h06;
  localparam logic [5:0] OffTgl    = 6'h07;
  localparam logic [5:0] OffRiseEn = 6'h08;
  localparam logic [5:0] OffFallEn = 6'h09;
  localparam logic [5:0] OffIrq    = 6'h0a;

  logic [CHANNELS-1:0] out_q, oe_q, med_q, strong_q, rise_q, fall_q, stat_q;
  logic [CHANNELS-1:0] out_d, oe_d, med_d, strong_d, rise_d, fall_d, stat_d;
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q, in_sync, bm, wd, edges;
  logic                ack_q;
  logic [31:0]         dat_q, rdata;
  logic                hit, req, wr;
  logic [5:0]          off;
  logic                unused_bits;

  assign hit = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q & hit;
  assign wr  = req & wbs.wbs_we_i;
  assign off = wbs.wbs_adr_i[7:2];
  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i, wbs.wbs_sel_i};

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign edges   = (in_sync & ~prev_q & rise_q) | (~in_sync & prev_q & fall_q);

  // Deselected byte lanes behave as zero data and leave their bits untouched.
  always_comb begin
    bm = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      bm[i] = wbs.wbs_sel_i[2'(i / 8)];
    end
  end
  assign wd = wbs.wbs_dat_i[CHANNELS-1:0] & bm;

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    med_d    = med_q;
    strong_d = strong_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    stat_d   = stat_q;
    if (wr) begin
      case (off)
        OffOut:    out_d    = (out_q & ~bm) | wd;
        OffOe:     oe_d     = (oe_q & ~bm) | wd;
        OffMed:    med_d    = (med_q & ~bm) | wd;
        OffStrong: strong_d = (strong_q & ~bm) | wd;
        OffSet:    out_d    = out_q | wd;
        OffClr:    out_d    = out_q & ~wd;
        OffTgl:    out_d    = out_q ^ wd;
        OffRiseEn: rise_d   = (rise_q & ~bm) | wd;
        OffFallEn: fall_d   = (fall_q & ~bm) | wd;
        OffIrq:    stat_d   = stat_q & ~wd;
        default:   ;
      endcase
    end
    // A fresh edge overrides a same-cycle W1C.
    stat_d = stat_d | edges;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OffOut:    rdata = 32'(out_q);
      OffOe:     rdata = 32'(oe_q);
      OffMed:    rdata = 32'(med_q);
      OffStrong: rdata = 32'(strong_q);
      OffIn:     rdata = 32'(in_sync);
      OffRiseEn: rdata = 32'(rise_q);
      OffFallEn: rdata = 32'(fall_q);
      OffIrq:    rdata = 32'(stat_q);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q    <= '0;
      oe_q     <= '0;
      med_q    <= '0;
      strong_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      stat_q   <= '0;
      prev_q   <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      med_q    <= med_d;
      strong_q <= strong_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stat_q   <= stat_d;
      prev_q   <= in_sync;
      ack_q    <= req;
      dat_q    <= (req & ~wbs.wbs_we_i) ? rdata : 32'h0;
      sync_q[0] <= fastio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wbs.wbs_ack_o        = ack_q;
  assign wbs.wbs_dat_o        = dat_q;
  assign fastio_out_l         = ~out_q;
  assign fastio_oe_l          = ~oe_q;
  assign fastio_med_enable    = med_q & ~strong_q;
  assign fastio_strong_enable = strong_q;
  assign irq                  = |stat_q;

endmodule
